// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the MDU sequencer: op codes, FSM states and op-class helpers.
package md_sequencer_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// E/D-stage request side and HI/LO/stall response side of the MDU sequencer.
interface md_sequencer_if;
    import md_sequencer_pkg::*;

    // No valid/ready pair here: E_MDOp == MD_NONE is the idle value, and MDStall is the
    // only back-pressure, telling the hazard unit to hold D while an op is in flight.
    logic [3:0]  E_MDOp;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_IsMD;
    logic        Start;
    logic        Busy;
    logic        MDStall;
    logic [31:0] E_MDOut;
    logic [31:0] HI;
    logic [31:0] LO;
    md_state_e   dbg_state;

    modport master (
        output E_MDOp, E_A, E_B, D_IsMD,
        input  Start, Busy, MDStall, E_MDOut, HI, LO, dbg_state
    );

    modport slave (
        input  E_MDOp, E_A, E_B, D_IsMD,
        output Start, Busy, MDStall, E_MDOut, HI, LO, dbg_state
    );

endinterface

// File: rtl/md_sequencer_arith.sv
// Combinational MDU datapath: {HI,LO} result for mult/multu/div/divu plus a hold flag for divide by zero.
module md_sequencer_arith
    import md_sequencer_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        hold
);

    logic [63:0] s_prod;
    logic [63:0] u_prod;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] sdiv_b;
    logic [31:0] udiv_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] s_q;
    logic [31:0] s_r;
    logic [31:0] u_q;
    logic [31:0] u_r;

    // Low 64 bits of a product of sign-extended operands equal the signed 64-bit product.
    assign s_prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign u_prod = {32'd0, a} * {32'd0, b};

    // Signed divide through magnitudes so 0x80000000 / -1 wraps instead of overflowing.
    assign abs_a  = a[31] ? (32'd0 - a) : a;
    assign abs_b  = b[31] ? (32'd0 - b) : b;
    assign sdiv_b = (b == 32'd0) ? 32'd1 : abs_b;
    assign udiv_b = (b == 32'd0) ? 32'd1 : b;
    assign mag_q  = abs_a / sdiv_b;
    assign mag_r  = abs_a % sdiv_b;
    assign s_q    = (a[31] ^ b[31]) ? (32'd0 - mag_q) : mag_q;
    assign s_r    = a[31] ? (32'd0 - mag_r) : mag_r;
    assign u_q    = a / udiv_b;
    assign u_r    = a % udiv_b;

    always_comb begin
        result = 64'd0;
        hold   = 1'b0;
        case (op)
            MD_MULT:  result = s_prod;
            MD_MULTU: result = u_prod;
            MD_DIV: begin
                result = {s_r, s_q};
                hold   = (b == 32'd0);
            end
            MD_DIVU: begin
                result = {u_r, u_q};
                hold   = (b == 32'd0);
            end
            default: begin
                result = 64'd0;
                hold   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// MDU sequencer: IDLE/RUN FSM with busy counter, pending result and HI/LO registers for the E stage.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)(
    input  logic          clk,
    input  logic          reset,
    md_sequencer_if.slave md
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    md_state_e        state;
    md_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_hold;
    logic [63:0]      arith_res;
    logic             arith_hold;
    logic             start;
    logic             busy;
    logic             done;

    md_sequencer_arith u_arith (
        .op     (md.E_MDOp),
        .a      (md.E_A),
        .b      (md.E_B),
        .result (arith_res),
        .hold   (arith_hold)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (is_muldiv(md.E_MDOp)) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == CNT_W'(1)) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        start = (state == ST_IDLE) && is_muldiv(md.E_MDOp);
        busy  = (state == ST_RUN);
        done  = (state == ST_RUN) && (cnt == CNT_W'(1));
    end

    // Result is computed at acceptance and parked until the counter expires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            pend_hi   <= 32'd0;
            pend_lo   <= 32'd0;
            pend_hold <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            if (start) begin
                cnt       <= is_div(md.E_MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                pend_hi   <= arith_res[63:32];
                pend_lo   <= arith_res[31:0];
                pend_hold <= arith_hold;
            end else if (busy) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (done) begin
                if (!pend_hold) begin
                    hi_q <= pend_hi;
                    lo_q <= pend_lo;
                end
            end else if (state == ST_IDLE) begin
                if (md.E_MDOp == MD_MTHI) hi_q <= md.E_A;
                if (md.E_MDOp == MD_MTLO) lo_q <= md.E_A;
            end
        end
    end

    always_comb begin
        md.E_MDOut = 32'd0;
        if (md.E_MDOp == MD_MFHI) md.E_MDOut = hi_q;
        if (md.E_MDOp == MD_MFLO) md.E_MDOut = lo_q;
    end

    assign md.Start     = start;
    assign md.Busy      = busy;
    assign md.MDStall   = md.D_IsMD & (start | busy);
    assign md.HI        = hi_q;
    assign md.LO        = lo_q;
    assign md.dbg_state = state;

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed cases plus random op streams against a cycle-level reference model.
module tb_md_sequencer;
    import md_sequencer_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;

    md_sequencer_if bus ();

    md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: architectural HI/LO, remaining busy cycles, queued {write_en, HI, LO}.
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          m_rem;
    logic [64:0] exp_q[$];

    int          busy_seen;
    int          stall_seen;
    logic [31:0] last_out;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        logic [63:0]     bits;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (op)
            MD_MULT: begin
                q = sa * sb;
                bits = q;
                return {1'b1, bits};
            end
            MD_MULTU: begin
                up = ua * ub;
                return {1'b1, up};
            end
            MD_DIV: begin
                if (b == 32'd0) return 65'd0;
                q = sa / sb;
                r = sa % sb;
                return {1'b1, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return 65'd0;
                up = ua / ub;
                bits = ua % ub;
                return {1'b1, bits[31:0], up[31:0]};
            end
        endcase
    endfunction

    task automatic model_reset();
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        m_rem = 0;
        exp_q.delete();
    endtask

    // One E-stage cycle: drive, check at the falling edge, advance the model past the rising edge.
    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic d);
        logic        e_busy;
        logic        e_start;
        logic [31:0] e_out;
        logic [64:0] r;
        bus.E_MDOp = op;
        bus.E_A    = a;
        bus.E_B    = b;
        bus.D_IsMD = d;
        @(negedge clk);
        e_busy  = (m_rem > 0);
        e_start = !e_busy && (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU});
        e_out   = (op == MD_MFHI) ? m_hi : (op == MD_MFLO) ? m_lo : 32'd0;
        check("start", 64'(bus.Start), 64'(e_start));
        check("busy", 64'(bus.Busy), 64'(e_busy));
        check("mdstall", 64'(bus.MDStall), 64'(d & (e_start | e_busy)));
        check("e_mdout", 64'(bus.E_MDOut), 64'(e_out));
        check("hi", 64'(bus.HI), 64'(m_hi));
        check("lo", 64'(bus.LO), 64'(m_lo));
        if (bus.Busy) busy_seen++;
        if (bus.MDStall) stall_seen++;
        last_out = bus.E_MDOut;
        @(posedge clk);
        #1;
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && exp_q.size() > 0) begin
                r = exp_q.pop_front();
                if (r[64]) begin
                    m_hi = r[63:32];
                    m_lo = r[31:0];
                end
            end
        end else if (e_start) begin
            m_rem = (op == MD_DIV || op == MD_DIVU) ? DIV_N : MULT_N;
            exp_q.push_back(ref_result(op, a, b));
        end else if (op == MD_MTHI) begin
            m_hi = a;
        end else if (op == MD_MTLO) begin
            m_lo = a;
        end
    endtask

    task automatic idle(input int n, input logic d);
        for (int i = 0; i < n; i++) step(MD_NONE, 32'd0, 32'd0, d);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b0;
        bus.E_MDOp = MD_NONE;
        bus.E_A    = 32'd0;
        bus.E_B    = 32'd0;
        bus.D_IsMD = 1'b0;
        model_reset();
        busy_seen  = 0;
        stall_seen = 0;
        last_out   = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_hi", 64'(bus.HI), 64'd0);
        check("rst_lo", 64'(bus.LO), 64'd0);
        bus.E_MDOp = MD_MULT;
        bus.D_IsMD = 1'b1;
        #1;
        check("rst_start_follows", 64'(bus.Start), 64'd1);
        check("rst_stall_follows", 64'(bus.MDStall), 64'd1);
        bus.E_MDOp = MD_NONE;
        bus.D_IsMD = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // mult -2 * 3
        busy_seen = 0;
        step(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(MULT_N, 1'b0);
        check("mult_busy_cycles", 64'(busy_seen), 64'd5);
        check("mult_hi", 64'(bus.HI), 64'hFFFF_FFFF);
        check("mult_lo", 64'(bus.LO), 64'hFFFF_FFFA);

        // multu with D_IsMD held: stall through the accept cycle and all busy cycles
        stall_seen = 0;
        step(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
        idle(MULT_N, 1'b1);
        check("multu_stall_cycles", 64'(stall_seen), 64'd6);
        check("multu_hi", 64'(bus.HI), 64'd1);
        check("multu_lo", 64'(bus.LO), 64'hFFFF_FFFE);
        step(MD_MFHI, 32'd0, 32'd0, 1'b0);
        check("mfhi_after_multu", 64'(last_out), 64'd1);

        // div -7 / 2
        busy_seen = 0;
        step(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DIV_N, 1'b0);
        check("div_busy_cycles", 64'(busy_seen), 64'd10);
        check("div_lo", 64'(bus.LO), 64'hFFFF_FFFD);
        check("div_hi", 64'(bus.HI), 64'hFFFF_FFFF);

        // signed overflow case
        step(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DIV_N, 1'b0);
        check("div_ovf_lo", 64'(bus.LO), 64'h8000_0000);
        check("div_ovf_hi", 64'(bus.HI), 64'd0);

        // divu by zero leaves HI/LO alone after a full divide latency
        step(MD_MTHI, 32'h11, 32'd0, 1'b0);
        step(MD_MTLO, 32'h22, 32'd0, 1'b0);
        busy_seen = 0;
        step(MD_DIVU, 32'd7, 32'd0, 1'b0);
        idle(DIV_N, 1'b0);
        check("div0_busy_cycles", 64'(busy_seen), 64'd10);
        check("div0_hi", 64'(bus.HI), 64'h11);
        check("div0_lo", 64'(bus.LO), 64'h22);

        // mthi then mfhi
        busy_seen = 0;
        step(MD_MTHI, 32'h1234, 32'd0, 1'b0);
        step(MD_MFHI, 32'd0, 32'd0, 1'b0);
        check("mfhi_after_mthi", 64'(last_out), 64'h1234);
        check("mthi_no_busy", 64'(busy_seen), 64'd0);

        // reset in the middle of a mult
        step(MD_MTLO, 32'h66, 32'd0, 1'b0);
        step(MD_MULT, 32'd3, 32'd4, 1'b0);
        idle(2, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("midrst_busy", 64'(bus.Busy), 64'd0);
        check("midrst_hi", 64'(bus.HI), 64'd0);
        check("midrst_lo", 64'(bus.LO), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        busy_seen = 0;
        idle(MULT_N + 3, 1'b0);
        check("midrst_no_late_busy", 64'(busy_seen), 64'd0);
        check("midrst_no_late_hi", 64'(bus.HI), 64'd0);
        check("midrst_no_late_lo", 64'(bus.LO), 64'd0);

        // random op stream, including illegal ops issued while busy
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 8)), rand_operand(), rand_operand(),
                 1'($urandom_range(0, 1)));
        end
        idle(DIV_N + 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
